// File: rtl/median_pkg.sv
// Shared types and default geometry for the median filter pipeline.
// The column struct is the hand-off format that the median stage consumes.
package median_pkg;

  localparam int MEDIAN_DATA_W = 8;
  localparam int MEDIAN_LINE_W = 640;
  localparam int MEDIAN_ADDR_W = 10;

  typedef logic [MEDIAN_DATA_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t y1;
    pixel_t y0;
    pixel_t ym1;
  } column_t;

  // Address bits that actually index a line of the given depth.
  function automatic int index_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/median_line_ram.sv
// Single-address line store: asynchronous read, synchronous write, so a read
// and a write to the same address in one cycle return the old contents.
module median_line_ram
  import median_pkg::*;
#(
  parameter int DEPTH  = MEDIAN_LINE_W,
  parameter int WIDTH  = MEDIAN_DATA_W,
  parameter int ADDR_W = MEDIAN_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int IDX_W = index_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;

  // The caller never presents an address at or above DEPTH.
  assign idx     = addr[IDX_W-1:0];
  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wr_data;
    end
  end

endmodule

// File: rtl/median_column_buffer.sv
// Turns a raster pixel stream into vertical 3-pixel columns (rows y, y-1, y-2)
// using two chained line stores; one column per accepted pixel once primed.
module median_column_buffer
  import median_pkg::*;
#(
  parameter int DATA_W = MEDIAN_DATA_W,
  parameter int LINE_W = MEDIAN_LINE_W,
  parameter int ADDR_W = MEDIAN_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] x2_y1,
  output logic [DATA_W-1:0] x2_y0,
  output logic [DATA_W-1:0] x2_ym1,
  output logic              col_valid,
  output logic [ADDR_W-1:0] col_x
);

  localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(LINE_W - 1);
  localparam logic [1:0]        ROW_READY = 2'd2;

  logic [ADDR_W-1:0] x_cnt_reg, x_cnt_next;
  logic [1:0]        row_cnt_reg, row_cnt_next;
  logic [ADDR_W-1:0] ram_addr;
  logic              accept;
  logic              restart;
  logic              primed;
  logic [DATA_W-1:0] lb_wr [2];
  logic [DATA_W-1:0] lb_rd [2];

  assign accept   = pix_valid;
  assign restart  = pix_valid & sof;
  assign primed   = (row_cnt_reg == ROW_READY);
  // A frame restart always lands on column 0, whatever x_cnt was.
  assign ram_addr = restart ? '0 : x_cnt_reg;

  // lb0 holds row y-1, lb1 holds row y-2; lb1 is fed by lb0's old contents.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_wr[gi] = pix_in;
      end else begin : g_tail
        assign lb_wr[gi] = lb_rd[gi-1];
      end

      median_line_ram #(
        .DEPTH  (LINE_W),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_lb (
        .clk     (clk),
        .addr    (ram_addr),
        .we      (accept & ~rst),
        .wr_data (lb_wr[gi]),
        .rd_data (lb_rd[gi])
      );
    end
  endgenerate

  always_comb begin
    x_cnt_next   = x_cnt_reg;
    row_cnt_next = row_cnt_reg;
    if (restart) begin
      x_cnt_next   = ADDR_W'(1);
      row_cnt_next = 2'd0;
    end else if (accept) begin
      if (x_cnt_reg == X_LAST) begin
        x_cnt_next = '0;
        if (!primed) begin
          row_cnt_next = row_cnt_reg + 2'd1;
        end
      end else begin
        x_cnt_next = x_cnt_reg + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_reg   <= '0;
      row_cnt_reg <= 2'd0;
      col_valid   <= 1'b0;
      x2_y1       <= '0;
      x2_y0       <= '0;
      x2_ym1      <= '0;
      col_x       <= '0;
    end else begin
      x_cnt_reg   <= x_cnt_next;
      row_cnt_reg <= row_cnt_next;
      col_valid   <= accept & ~sof & primed;
      // Data registers hold through gaps so the median stage sees stable inputs.
      if (accept) begin
        x2_y1  <= pix_in;
        x2_y0  <= lb_rd[0];
        x2_ym1 <= lb_rd[1];
        col_x  <= ram_addr;
      end
    end
  end

endmodule

// File: tb/tb_median_column_buffer.sv
// Self-checking bench: directed priming/stall/ordering/restart scenarios plus a
// random stream, all scored against an image-level reference of the raster.
module tb_median_column_buffer;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          sof;
  logic [DW-1:0] x2_y1, x2_y0, x2_ym1;
  logic          col_valid;
  logic [AW-1:0] col_x;

  always #5 clk = ~clk;

  median_column_buffer #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .x2_y1     (x2_y1),
    .x2_y0     (x2_y0),
    .x2_ym1    (x2_ym1),
    .col_valid (col_valid),
    .col_x     (col_x)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: the frame as rows of pixels; row r lives in slot r%3.
  int img [3][LW];
  int m_row, m_x;
  bit m_known;
  int e_valid, e_y1, e_y0, e_ym1, e_x;
  int pulses;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int p, input bit v, input bit s, input bit r);
    if (r) begin
      m_row = 0; m_x = 0; e_valid = 0; m_known = 1;
      e_y1 = 0; e_y0 = 0; e_ym1 = 0; e_x = 0;
    end else if (v) begin
      if (s) begin
        m_row = 0; m_x = 0;
      end
      if (m_row >= 2) begin
        e_valid = 1; m_known = 1;
        e_y1 = p;
        e_y0 = img[(m_row - 1) % 3][m_x];
        e_ym1 = img[(m_row - 2) % 3][m_x];
        e_x = m_x;
      end else begin
        e_valid = 0; m_known = 0;
      end
      img[m_row % 3][m_x] = p;
      m_x++;
      if (m_x == LW) begin
        m_x = 0;
        m_row++;
      end
    end else begin
      e_valid = 0;
    end
  endtask

  task automatic step(input int p, input bit v, input bit s, input bit r);
    @(negedge clk);
    pix_in = DW'(p); pix_valid = v; sof = s; rst = r;
    @(posedge clk);
    model_edge(p, v, s, r);
    #1;
    check("col_valid", int'(col_valid), e_valid);
    if (m_known) begin
      check("x2_y1", int'(x2_y1), e_y1);
      check("x2_y0", int'(x2_y0), e_y0);
      check("x2_ym1", int'(x2_ym1), e_ym1);
      check("col_x", int'(col_x), e_x);
    end
    if (col_valid) pulses++;
    $display("t=%0t rst=%0b v=%0b sof=%0b pix=%0d -> cv=%0b col=(%0d,%0d,%0d) x=%0d",
             $time, r, v, s, p, col_valid, x2_y1, x2_y0, x2_ym1, col_x);
  endtask

  initial begin
    int perm [6][3];
    int k;
    perm = '{'{12, 32, 128}, '{12, 128, 32}, '{32, 12, 128},
             '{32, 128, 12}, '{128, 12, 32}, '{128, 32, 12}};
    rst = 1'b0; pix_in = '0; pix_valid = 1'b0; sof = 1'b0;
    m_known = 0; e_valid = 0; m_row = 0; m_x = 0;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Priming, continuous: directed column table for the third line
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(i, 1, i == 0, 0);
      if (i >= 8) begin
        k = i - 8;
        check("prime_cv", int'(col_valid), 1);
        check("prime_y1", int'(x2_y1), 8 + k);
        check("prime_y0", int'(x2_y0), 4 + k);
        check("prime_ym1", int'(x2_ym1), k);
        check("prime_x", int'(col_x), k);
      end
    end
    check("prime_pulses", pulses, 4);

    // Same stream with 1,0,0 gaps
    pulses = 0;
    k = 0;
    while (k < 12) begin
      step(k, 1, k == 0, 0);
      step(k, 0, 0, 0);
      step(255 - k, 0, k == 3, 0);
      k++;
    end
    check("stall_pulses", pulses, 4);

    // Three constant lines in every ordering; third line's x=0 gives (c,b,a)
    for (int o = 0; o < 6; o++) begin
      for (int ln = 0; ln < 3; ln++)
        for (int x = 0; x < LW; x++) begin
          step(perm[o][ln], 1, ln == 0 && x == 0, 0);
          if (ln == 2 && x == 0) begin
            check("perm_y1", int'(x2_y1), perm[o][2]);
            check("perm_y0", int'(x2_y0), perm[o][1]);
            check("perm_ym1", int'(x2_ym1), perm[o][0]);
          end
        end
    end

    // Mid-line sof after 2.5 lines
    for (int i = 0; i < 10; i++) step(40 + i, 1, i == 0, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) step(90 + i, 1, i == 0, 0);
    check("midsof_pulses", pulses, 4);

    // Reset mid-stream during line 3, then two fresh lines before output
    for (int i = 0; i < 10; i++) step(60 + i, 1, i == 0, 0);
    step(0, 0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) step(150 + i, 1, 0, 0);
    check("rst_silent", pulses, 0);
    for (int i = 0; i < 4; i++) step(200 + i, 1, 0, 0);
    check("rst_resume", pulses, 4);

    // Reset concurrent with a valid pixel: pixel dropped, restart at x=0
    step(255, 1, 1, 1);
    for (int i = 0; i < 9; i++) step(i + 1, 1, 0, 0);
    check("rst_drop_x", int'(col_x), 0);

    // Random stream with occasional sof and reset
    step(0, 1, 1, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 255), $urandom_range(0, 3) != 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 250) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
